// File: rtl/stencil2d_sched.sv
// Sequencer for the 3x3 stencil MAC: walks interior points, issues nine taps per point,
// and pairs returned results with their sol addresses through a small outstanding FIFO.
module stencil2d_sched #(
  parameter int unsigned ROW_SIZE  = 128,
  parameter int unsigned COL_SIZE  = 64,
  parameter int unsigned ADDR_W    = 13,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [3:0]        f_idx,
  output logic              acc_clr,
  output logic              acc_last,
  input  logic              res_valid,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              err
);

  localparam int unsigned PtrW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned RowW = $clog2(ROW_SIZE);
  localparam int unsigned ColW = $clog2(COL_SIZE);
  localparam logic [RowW-1:0]   RowLast = RowW'(ROW_SIZE - 3);
  localparam logic [ColW-1:0]   ColLast = ColW'(COL_SIZE - 3);
  localparam logic [CntW-1:0]   CntFull = CntW'(OUT_DEPTH);
  localparam logic [ADDR_W-1:0] RowStep = ADDR_W'(COL_SIZE - 2);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e              state_q;
  logic [RowW-1:0]     r_q;
  logic [ColW-1:0]     c_q;
  logic [3:0]          f_q;
  logic [ADDR_W-1:0]   pt_addr_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic                busy_q, done_q, rd_valid_q, acc_clr_q, acc_last_q, err_q;

  logic [ADDR_W-1:0]   fifo_mem [OUT_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     cnt_q, cnt_d;

  logic tap_acc, push, pop, fifo_empty, last_pt;

  always_comb begin
    tap_acc    = rd_valid_q & rd_ready;
    push       = tap_acc & acc_clr_q;
    fifo_empty = (cnt_q == '0);
    pop        = res_valid & ~fifo_empty;
    cnt_d      = cnt_q + CntW'(push) - CntW'(pop);
    last_pt    = (r_q == RowLast) && (c_q == ColLast);
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_valid = rd_valid_q;
  assign rd_addr  = rd_addr_q;
  assign f_idx    = f_q;
  assign acc_clr  = acc_clr_q;
  assign acc_last = acc_last_q;
  assign err      = err_q;
  assign wr_valid = pop;
  assign wr_addr  = fifo_empty ? '0 : fifo_mem[rd_ptr_q];

  // Outstanding-point FIFO; memory needs no reset because wr_addr is gated when empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr_q] <= pt_addr_q;
        wr_ptr_q           <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
      if (res_valid && fifo_empty) err_q <= 1'b1;
    end
  end

  // rd_addr tracks the tap incrementally: +1 along a row, +COL-2 to the next window row.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      r_q        <= '0;
      c_q        <= '0;
      f_q        <= '0;
      pt_addr_q  <= '0;
      rd_addr_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      acc_clr_q  <= 1'b0;
      acc_last_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StRun;
            busy_q     <= 1'b1;
            r_q        <= '0;
            c_q        <= '0;
            f_q        <= '0;
            pt_addr_q  <= '0;
            rd_addr_q  <= '0;
            acc_clr_q  <= 1'b1;
            acc_last_q <= 1'b0;
            rd_valid_q <= (cnt_d != CntFull);
          end
        end
        StRun: begin
          if (tap_acc) begin
            if (f_q == 4'd8) begin
              f_q        <= '0;
              acc_last_q <= 1'b0;
              if (last_pt) begin
                state_q    <= StDrain;
                rd_valid_q <= 1'b0;
                acc_clr_q  <= 1'b0;
                rd_addr_q  <= '0;
              end else begin
                if (c_q == ColLast) begin
                  c_q       <= '0;
                  r_q       <= r_q + 1'b1;
                  pt_addr_q <= pt_addr_q + ADDR_W'(3);
                  rd_addr_q <= pt_addr_q + ADDR_W'(3);
                end else begin
                  c_q       <= c_q + 1'b1;
                  pt_addr_q <= pt_addr_q + ADDR_W'(1);
                  rd_addr_q <= pt_addr_q + ADDR_W'(1);
                end
                acc_clr_q  <= 1'b1;
                rd_valid_q <= (cnt_d != CntFull);
              end
            end else begin
              f_q        <= f_q + 4'd1;
              rd_addr_q  <= (f_q == 4'd2 || f_q == 4'd5) ? rd_addr_q + RowStep
                                                         : rd_addr_q + ADDR_W'(1);
              acc_clr_q  <= 1'b0;
              acc_last_q <= (f_q == 4'd7);
              rd_valid_q <= 1'b1;
            end
          end else begin
            rd_valid_q <= !((f_q == 4'd0) && (cnt_d == CntFull));
          end
        end
        StDrain: begin
          if (fifo_empty) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_stencil2d_sched.sv
// Randomized bench for stencil2d_sched on a 4x5 grid against a loop-built tap/write model.
module tb_stencil2d_sched;
  localparam int R     = 4;
  localparam int C     = 5;
  localparam int AW    = 13;
  localparam int D     = 4;
  localparam int NPTS  = (R - 2) * (C - 2);
  localparam int NTAPS = NPTS * 9;

  logic clk = 1'b0;
  logic rst, start, rd_ready, res_valid;
  logic busy, done, rd_valid, acc_clr, acc_last, wr_valid, err;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [3:0] f_idx;

  int total = 0;
  int bad   = 0;
  int exp_addr[$];
  int exp_f[$];
  int exp_wr[$];

  always #5 clk = ~clk;

  stencil2d_sched #(
    .ROW_SIZE (R),
    .COL_SIZE (C),
    .ADDR_W   (AW),
    .OUT_DEPTH(D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_addr  (rd_addr),
    .f_idx    (f_idx),
    .acc_clr  (acc_clr),
    .acc_last (acc_last),
    .res_valid(res_valid),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .err      (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic build_model();
    for (int r = 0; r < R - 2; r++)
      for (int c = 0; c < C - 2; c++) begin
        exp_wr.push_back(r * C + c);
        for (int k1 = 0; k1 < 3; k1++)
          for (int k2 = 0; k2 < 3; k2++) begin
            exp_addr.push_back((r + k1) * C + (c + k2));
            exp_f.push_back(k1 * 3 + k2);
          end
      end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_rd_valid"}, rd_valid, 0);
    check_eq({tag, "_acc_clr"}, acc_clr, 0);
    check_eq({tag, "_acc_last"}, acc_last, 0);
    check_eq({tag, "_rd_addr"}, rd_addr, 0);
    check_eq({tag, "_f_idx"}, f_idx, 0);
    check_eq({tag, "_err"}, err, 0);
    check_eq({tag, "_wr_valid"}, wr_valid, 0);
    check_eq({tag, "_wr_addr"}, wr_addr, 0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; start = 1'b0; rd_ready = 1'b0; res_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs(tag);
    rst = 1'b0;
  endtask

  // Full pass: results return 3 cycles after each acc_last acceptance.
  task automatic run_pass(input bit rdy_rand, input int abort_at);
    int tap_i = 0;
    int wr_i  = 0;
    int outst = 0;
    int cyc   = 0;
    int due[$];
    bit acc_s, wv_s, rv_s;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (wr_i < NPTS) begin
      if (cyc > 3000) begin
        check_eq("pass_timeout", cyc, 0);
        return;
      end
      rd_ready  = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      rv_s      = (due.size() > 0) && (due[0] == cyc);
      res_valid = rv_s;
      #1;
      check_eq("busy", busy, 1);
      check_eq("rd_valid", rd_valid, (tap_i < NTAPS) && !((tap_i % 9 == 0) && (outst == D)));
      if (rd_valid && tap_i < NTAPS) begin
        check_eq("rd_addr", rd_addr, exp_addr[tap_i]);
        check_eq("f_idx", f_idx, exp_f[tap_i]);
        check_eq("acc_clr", acc_clr, tap_i % 9 == 0);
        check_eq("acc_last", acc_last, tap_i % 9 == 8);
      end
      check_eq("wr_valid", wr_valid, rv_s && (outst > 0));
      if (wr_valid && wr_i < NPTS) check_eq("wr_addr", wr_addr, exp_wr[wr_i]);
      acc_s = rd_valid && rd_ready;
      wv_s  = wr_valid;
      @(posedge clk); #1;
      if (rv_s) void'(due.pop_front());
      if (acc_s) begin
        if (tap_i % 9 == 0) outst++;
        if (tap_i % 9 == 8) due.push_back(cyc + 3);
        tap_i++;
      end
      if (wv_s) begin
        outst--;
        wr_i++;
      end
      cyc++;
      if (abort_at > 0 && tap_i == abort_at) begin
        do_reset("abort");
        return;
      end
    end
    res_valid = 1'b0;
    rd_ready  = 1'b1;
    check_eq("tap_total", tap_i, NTAPS);
    #1;
    check_eq("drain_busy", busy, 1);
    check_eq("drain_done", done, 0);
    check_eq("drain_rd_valid", rd_valid, 0);
    @(posedge clk); #1;
    check_eq("done_pulse", done, 1);
    check_eq("done_busy", busy, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("done_single", done, 0);
    check_eq("idle_busy", busy, 0);
    @(posedge clk); #1;
    check_eq("start_in_done_ignored", busy, 0);
  endtask

  task automatic fifo_full_test();
    int acc = 0;
    res_valid = 1'b0;
    rd_ready  = 1'b1;
    start     = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 60; i++) begin
      start = (i % 7 == 3);
      if (rd_valid) acc++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check_eq("full_taps", acc, 36);
    check_eq("full_rd_valid", rd_valid, 0);
    check_eq("full_f_idx", f_idx, 0);
    check_eq("full_busy", busy, 1);
    res_valid = 1'b1;
    #1;
    check_eq("full_wr_valid", wr_valid, 1);
    check_eq("full_wr_addr", wr_addr, 0);
    @(posedge clk); #1;
    res_valid = 1'b0;
    #1;
    check_eq("resume_rd_valid", rd_valid, 1);
    check_eq("resume_rd_addr", rd_addr, 6);
    check_eq("resume_next_head", wr_addr, 1);
    do_reset("rst_from_run");
  endtask

  task automatic protocol_err_test();
    res_valid = 1'b1;
    #1;
    check_eq("perr_wr_valid", wr_valid, 0);
    @(posedge clk); #1;
    res_valid = 1'b0;
    check_eq("perr_err", err, 1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("perr_sticky", err, 1);
    do_reset("perr_clear");
  endtask

  initial begin
    build_model();
    do_reset("reset");
    run_pass(1'b0, 0);
    run_pass(1'b1, 0);
    fifo_full_test();
    run_pass(1'b0, 20);
    run_pass(1'b0, 0);
    protocol_err_test();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/stencil2d_sched.md
# stencil2d_sched

Sequencing controller for the 3x3 2D stencil MAC datapath. On a start pulse it walks every interior output point of the ROW_SIZE x COL_SIZE grid in row-major order and issues the nine (orig address, filter index) taps per point to the read port with a valid/ready handshake. It frames each point for the accumulator with clear/last strobes and pairs each returned datapath result with its sol write address through a small outstanding-address FIFO. It sits between the top-level control and the shared orig/filter read port plus the MAC/accumulator.

## Interface
- ROW_SIZE, 128, grid rows
- COL_SIZE, 64, grid columns
- ADDR_W, 13, address width; must satisfy 2^ADDR_W >= ROW_SIZE*COL_SIZE
- OUT_DEPTH, 4, outstanding-point FIFO depth (power of 2, >= 2)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a pass; sampled only in IDLE
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse in DONE
- rd_valid  out  1  tap request valid
- rd_ready  in  1  read port accepts tap; tap accepted when rd_valid & rd_ready
- rd_addr  out  ADDR_W  orig address (r+k1)*COL_SIZE + (c+k2)
- f_idx  out  4  filter index k1*3+k2
- acc_clr  out  1  high with tap k1=0,k2=0
- acc_last  out  1  high with tap k1=2,k2=2
- res_valid  in  1  datapath result for oldest outstanding point
- wr_valid  out  1  write sol at wr_addr
- wr_addr  out  ADDR_W  sol address r*COL_SIZE + c of oldest outstanding point
- err  out  1  sticky: res_valid received with FIFO empty

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - If start = 1, clear r, c, k1, k2 to 0 and go to RUN.
  - start in any other state is ignored.
- RUN:
  - Counters nest as k2 (0..2, innermost), k1 (0..2), c (0..COL_SIZE-3), r (0..ROW_SIZE-3, outermost).
  - The counters advance only on an accepted tap.
  - rd_addr, f_idx, acc_clr and acc_last are decoded from the registered counters. No combinational path runs from rd_ready to these outputs.
  - A new point may start only if a FIFO slot is free: rd_valid = 0 when k1=k2=0 and FIFO count = OUT_DEPTH. Otherwise rd_valid = 1.
  - An accepted tap with acc_clr pushes r*COL_SIZE+c into the FIFO.
  - An accepted tap with acc_last at r=ROW_SIZE-3, c=COL_SIZE-3 goes to DRAIN.
- DRAIN:
  - rd_valid = 0.
  - Go to DONE in the cycle after the FIFO becomes empty.
  - If the FIFO is already empty on entry, go to DONE on the next edge.
- DONE: done = 1 for exactly one cycle, then go to IDLE.
- Result pairing:
  - wr_valid = res_valid & FIFO non-empty (combinational). wr_addr = FIFO head.
  - When wr_valid = 1, the FIFO pops.
  - Push and pop in the same cycle leave the count unchanged; the push at full is already prevented.
- res_valid with an empty FIFO (in any state):
  - no write, no pop;
  - err is set and stays set until rst.
- Border rows and columns of sol are never written by this block.
- Totals for the defaults: 126*62 = 7812 points, 70308 taps, 7812 writes per pass.

## Timing
- Reset (sync, rst = 1 at an edge):
  - State goes to IDLE and all counters clear.
  - The FIFO is flushed and err clears.
  - Registered outputs are 0 after that edge: busy, done, rd_valid, acc_clr, acc_last, rd_addr, f_idx, err.
  - wr_valid = 0 while the FIFO is empty; wr_addr reads as 0.
- rst in mid-RUN or DRAIN aborts the pass. Outstanding addresses are discarded. Any later res_valid then sets err.
- start is sampled at edge N in IDLE:
  - busy = 1 and rd_valid = 1 from cycle N+1.
  - The first tap is rd_addr 0, f_idx 0, acc_clr 1.
- With rd_ready held high and the FIFO never full, one tap is accepted per cycle.
- A stalled tap holds rd_addr, f_idx, acc_clr and acc_last stable until accepted. No skipped or repeated taps.
- done is asserted one cycle after DRAIN observes an empty FIFO. busy = 0 in DONE. A start in the DONE cycle is ignored.
- Datapath result latency is arbitrary. Ordering is strictly FIFO.

## Test plan
- Reset: assert rst for 2 cycles, from RUN and from IDLE -> all outputs 0, busy 0, err 0. start on the first cycle after reset -> first tap at addr 0.
- Small grid ROW_SIZE=4, COL_SIZE=5, rd_ready=1, res_valid returned 3 cycles after each acc_last acceptance:
  - 6 points, 54 taps;
  - first point rd_addr 0,1,2,5,6,7,10,11,12 with f_idx 0..8;
  - wr_addr sequence 0,1,2,5,6,7;
  - a single done pulse after the last write.
- Backpressure: rd_ready pseudo-random at 50% on the same grid -> tap sequence identical to the unstalled run, 54 acceptances, strobes held during stalls.
- FIFO full: OUT_DEPTH=4, res_valid withheld:
  - exactly 36 taps accepted, then rd_valid = 0 at k1=k2=0;
  - one res_valid -> wr_addr 0, then taps resume at the next cycle;
  - start pulses during busy are ignored.
- Protocol error: res_valid pulsed in IDLE with an empty FIFO -> wr_valid 0, err = 1 and stays set until rst.
- Abort: rst at the 20th accepted tap -> IDLE on the next cycle with FIFO empty. A new start restarts from rd_addr 0, and the full 4x5 pass completes correctly.
